// File: rtl/onewire_pkg.sv
// onewire_pkg: shared definitions for the 1-Wire master.
//   op_t      : command operation codes (cmd_op).
//   state_t   : master FSM state encoding (also exported on dbg_state).
//   timing_t  : per-phase durations in 1 us ticks.
//   get_timing: returns the standard or overdrive timing set.
package onewire_pkg;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_BIT   = 2'b01,
        OP_BYTE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_LOW  = 3'd1,
        ST_RST_REC  = 3'd2,
        ST_SLOT_LOW = 3'd3,
        ST_SLOT_REC = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int PH_W = 10;

    // Standard speed, in ticks
    localparam logic [PH_W-1:0] STD_RST_LOW = 10'd480;
    localparam logic [PH_W-1:0] STD_PRS     = 10'd70;
    localparam logic [PH_W-1:0] STD_RST_REC = 10'd410;
    localparam logic [PH_W-1:0] STD_LOW1    = 10'd6;
    localparam logic [PH_W-1:0] STD_LOW0    = 10'd60;
    localparam logic [PH_W-1:0] STD_SAMPLE  = 10'd15;
    localparam logic [PH_W-1:0] STD_SLOT    = 10'd70;

    // Overdrive speed, in ticks
    localparam logic [PH_W-1:0] OVD_RST_LOW = 10'd70;
    localparam logic [PH_W-1:0] OVD_PRS     = 10'd8;
    localparam logic [PH_W-1:0] OVD_RST_REC = 10'd40;
    localparam logic [PH_W-1:0] OVD_LOW1    = 10'd1;
    localparam logic [PH_W-1:0] OVD_LOW0    = 10'd8;
    localparam logic [PH_W-1:0] OVD_SAMPLE  = 10'd2;
    localparam logic [PH_W-1:0] OVD_SLOT    = 10'd10;

    typedef struct packed {
        logic [PH_W-1:0] rst_low;
        logic [PH_W-1:0] prs;
        logic [PH_W-1:0] rst_rec;
        logic [PH_W-1:0] low1;
        logic [PH_W-1:0] low0;
        logic [PH_W-1:0] sample;
        logic [PH_W-1:0] slot;
    } timing_t;

    function automatic timing_t get_timing(input logic ovd);
        timing_t t;
        if (ovd) t = '{OVD_RST_LOW, OVD_PRS, OVD_RST_REC, OVD_LOW1, OVD_LOW0, OVD_SAMPLE, OVD_SLOT};
        else     t = '{STD_RST_LOW, STD_PRS, STD_RST_REC, STD_LOW1, STD_LOW0, STD_SAMPLE, STD_SLOT};
        return t;
    endfunction

endpackage

// File: rtl/onewire_tick.sv
// onewire_tick: 1 us tick prescaler.
//   clk  : clock
//   rst  : synchronous active-high reset (count to 0)
//   clr  : restart count at 0 (command acceptance)
//   tick : high for one clk when the count sits at CDR-1
module onewire_tick #(
    parameter int CDR = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CDR > 1) ? $clog2(CDR) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(CDR - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)   r_cnt <= '0;
        else if (tick)    r_cnt <= '0;
        else              r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/onewire_master.sv
// onewire_master: 1-Wire bus master (reset/presence, single bit, byte).
//   cmd_valid/cmd_ready/cmd_op/cmd_dat/cmd_ovd : command request
//   rsp_valid/rsp_dat/rsp_prs/rsp_err          : completion response
//   owr_e : 1 pulls the bus low, owr_i : synchronised bus level
//   dbg_state : current FSM state
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse with no backpressure; rsp_* hold until the next pulse.
module onewire_master import onewire_pkg::*; #(
    parameter int CDR    = 50,
    parameter int OVD_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_dat,
    input  logic       cmd_ovd,
    output logic       rsp_valid,
    output logic [7:0] rsp_dat,
    output logic       rsp_prs,
    output logic       rsp_err,
    output logic       owr_e,
    input  logic       owr_i,
    output state_t     dbg_state
);
    state_t          r_state;
    logic [PH_W-1:0] r_ph;        // position within reset phase or bit slot
    logic [7:0]      r_shift;     // tx bits leave at [0], rx bits enter at [7]
    logic [2:0]      r_bits_left;
    logic            r_cur_bit;   // bit being sent in the current slot
    logic            r_is_byte;
    logic            r_ovd;
    logic            r_prs;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_dat;
    logic            r_rsp_prs;
    logic            r_rsp_err;
    logic            r_owr_e;

    logic    w_tick;
    logic    w_accept;
    logic    w_ovd_req;
    logic    w_low_last;
    timing_t w_tm;

    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_ovd_req  = (OVD_EN != 0) && cmd_ovd;
    assign w_tm       = get_timing(r_ovd);
    assign w_low_last = (r_ph == (r_cur_bit ? w_tm.low1 : w_tm.low0) - 10'd1);

    onewire_tick #(.CDR(CDR)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ph        <= '0;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_cur_bit   <= 1'b0;
            r_is_byte   <= 1'b0;
            r_ovd       <= 1'b0;
            r_prs       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_prs   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_owr_e     <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_ovd       <= w_ovd_req;
                        r_ph        <= '0;
                        r_prs       <= 1'b0;
                        r_shift     <= cmd_dat;
                        r_cur_bit   <= cmd_dat[0];
                        r_is_byte   <= (cmd_op == OP_BYTE);
                        r_bits_left <= (cmd_op == OP_BYTE) ? 3'd7 : 3'd0;
                        case (cmd_op)
                            OP_RESET: begin
                                r_state <= ST_RST_LOW;
                                r_owr_e <= 1'b1;
                            end
                            OP_BIT, OP_BYTE: begin
                                r_state <= ST_SLOT_LOW;
                                r_owr_e <= 1'b1;
                            end
                            default: begin
                                r_state     <= ST_DONE;
                                r_rsp_valid <= 1'b1;
                                r_rsp_dat   <= '0;
                                r_rsp_prs   <= 1'b0;
                                r_rsp_err   <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_RST_LOW: begin
                    if (w_tick) begin
                        if (r_ph == w_tm.rst_low - 10'd1) begin
                            r_ph    <= '0;
                            r_owr_e <= 1'b0;
                            r_state <= ST_RST_REC;
                        end else begin
                            r_ph <= r_ph + 10'd1;
                        end
                    end
                end
                ST_RST_REC: begin
                    if (w_tick) begin
                        r_ph <= r_ph + 10'd1;
                        if (r_ph == w_tm.prs - 10'd1) r_prs <= ~owr_i;
                        if (r_ph == w_tm.rst_rec - 10'd1) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_dat   <= '0;
                            r_rsp_prs   <= r_prs;
                            r_rsp_err   <= ~owr_i;
                        end
                    end
                end
                ST_SLOT_LOW, ST_SLOT_REC: begin
                    // The slot counter spans the low and recovery phases, so
                    // the sample point is independent of the low-pulse width.
                    if (w_tick) begin
                        r_ph <= r_ph + 10'd1;
                        if (r_ph == w_tm.sample - 10'd1)
                            r_shift <= {owr_i, r_shift[7:1]};
                        if (r_state == ST_SLOT_LOW && w_low_last) begin
                            r_owr_e <= 1'b0;
                            r_state <= ST_SLOT_REC;
                        end
                        if (r_state == ST_SLOT_REC && r_ph == w_tm.slot - 10'd1) begin
                            if (r_bits_left != 3'd0) begin
                                // Sample already shifted in, so [0] is the next tx bit
                                r_bits_left <= r_bits_left - 3'd1;
                                r_ph        <= '0;
                                r_cur_bit   <= r_shift[0];
                                r_owr_e     <= 1'b1;
                                r_state     <= ST_SLOT_LOW;
                            end else begin
                                r_state     <= ST_DONE;
                                r_rsp_valid <= 1'b1;
                                r_rsp_dat   <= r_is_byte ? r_shift : {7'd0, r_shift[7]};
                                r_rsp_prs   <= 1'b0;
                                r_rsp_err   <= ~owr_i;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_owr_e     <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_prs   = r_rsp_prs;
    assign rsp_err   = r_rsp_err;
    assign owr_e     = r_owr_e;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: directed and random commands against a behavioural
// model of 1-Wire timing, with a pulled-up bus, a presence-pulse slave and
// bench-driven bus faults.
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int CDR   = 4;
    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_dat = 8'h00;
    logic       cmd_ovd = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_dat;
    logic       rsp_prs;
    logic       rsp_err;
    logic       owr_e;
    logic       owr_i;
    state_t     dbg_state;

    logic slave_en  = 1'b0;
    logic slave_low = 1'b0;
    logic bench_low = 1'b0;
    logic stuck     = 1'b0;
    logic poke      = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // scoreboard: expected low-pulse widths in clk cycles, plus response
    logic [15:0] exp_q[$];
    int          pulse_q[$];
    int          exp_lat;
    logic [7:0]  exp_dat;
    logic        exp_prs;
    logic        exp_err;

    // open-drain bus with pull-up
    assign owr_i = ~(owr_e | slave_low | bench_low | stuck);

    onewire_master #(.CDR(CDR), .OVD_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dat   (cmd_dat),
        .cmd_ovd   (cmd_ovd),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_prs   (rsp_prs),
        .rsp_err   (rsp_err),
        .owr_e     (owr_e),
        .owr_i     (owr_i),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // low-pulse monitor on owr_e
    int run_len = 0;
    always @(negedge clk) begin
        if (owr_e === 1'b1) run_len++;
        else if (run_len != 0) begin
            pulse_q.push_back(run_len);
            run_len = 0;
        end
    end

    // slave model: presence pulse after a standard or overdrive reset
    initial begin
        int low_len;
        low_len = 0;
        forever begin
            @(negedge clk);
            if (owr_e === 1'b1) low_len++;
            else begin
                if (slave_en && low_len >= 480 * CDR) begin
                    repeat (20 * CDR) @(negedge clk);
                    slave_low = 1'b1;
                    repeat (100 * CDR) @(negedge clk);
                    slave_low = 1'b0;
                end else if (slave_en && low_len >= 70 * CDR) begin
                    repeat (3 * CDR) @(negedge clk);
                    slave_low = 1'b1;
                    repeat (12 * CDR) @(negedge clk);
                    slave_low = 1'b0;
                end
                low_len = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: timing and results straight from the protocol rules
    task automatic model(input logic [1:0] op, input logic [7:0] dat, input logic ovd,
                         input logic [7:0] mask);
        int nbits;
        exp_q.delete();
        exp_dat = 8'h00;
        exp_prs = 1'b0;
        exp_err = 1'b0;
        if (op == 2'b00) begin
            exp_lat = (ovd ? 70 + 40 : 480 + 410) * CDR;
            exp_q.push_back(16'((ovd ? 70 : 480) * CDR));
            exp_prs = stuck | slave_en;
            exp_err = stuck;
        end else if (op == 2'b11) begin
            exp_lat = 0;
        end else begin
            nbits   = (op == 2'b10) ? 8 : 1;
            exp_lat = nbits * (ovd ? 10 : 70) * CDR;
            for (int i = 0; i < nbits; i++) begin
                exp_q.push_back(16'((dat[i] ? (ovd ? 1 : 6) : (ovd ? 8 : 60)) * CDR));
                exp_dat[i] = dat[i] & ~mask[i] & ~stuck;
            end
            exp_err = stuck;
        end
    endtask

    // driver: issue one command, await response, compare to model
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] dat, input logic ovd,
                          input logic [7:0] mask);
        int w;
        int lat;
        int nslots;
        model(op, dat, ovd, mask);
        nslots = (op == 2'b10) ? 8 : ((op == 2'b01) ? 1 : 0);
        @(negedge clk);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before", 32'(cmd_ready), 32'd1);
        pulse_q.delete();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dat   = dat;
        cmd_ovd   = ovd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        fork
            begin
                for (int i = 0; i < nslots; i++) begin
                    bench_low = mask[i];
                    repeat (30 * CDR) @(posedge clk);
                    #1 bench_low = 1'b0;
                    repeat (40 * CDR) @(posedge clk);
                    #1;
                end
                bench_low = 1'b0;
            end
            begin
                if (poke) begin
                    repeat (20 * CDR) @(posedge clk);
                    #1 cmd_valid = 1'b1;
                    @(negedge clk);
                    check("ready_busy", 32'(cmd_ready), 32'd0);
                    repeat (3) @(posedge clk);
                    #1 cmd_valid = 1'b0;
                end
            end
            begin
                @(negedge clk);
                while (rsp_valid !== 1'b1 && lat < LIMIT) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                end
            end
        join
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_dat", 32'(rsp_dat), 32'(exp_dat));
        check("rsp_prs", 32'(rsp_prs), 32'(exp_prs));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("pulse_cnt", 32'(pulse_q.size()), 32'(exp_q.size()));
        while (exp_q.size() != 0 && pulse_q.size() != 0)
            check("pulse_len", 32'(pulse_q.pop_front()), 32'(exp_q.pop_front()));
        @(negedge clk);
        check("valid_pulse", 32'(rsp_valid), 32'd0);
        check("ready_after", 32'(cmd_ready), 32'd1);
        check("dat_hold", 32'(rsp_dat), 32'(exp_dat));
    endtask

    initial begin
        int rv_cnt;
        int oe_cnt;
        logic [1:0] r_op;
        logic       r_ovd;

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_dat", 32'(rsp_dat), 32'd0);
        check("rst_prs", 32'(rsp_prs), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_owr_e", 32'(owr_e), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // reset with and without a slave
        slave_en = 1'b1;
        do_cmd(2'b00, 8'h00, 1'b0, 8'h00);
        slave_en = 1'b0;
        do_cmd(2'b00, 8'h00, 1'b0, 8'h00);

        // byte writes, passive pull-up and bench-forced zeros
        do_cmd(2'b10, 8'hA5, 1'b0, 8'h00);
        do_cmd(2'b10, 8'hFF, 1'b0, 8'h0A);

        // reserved op and an overdrive reset
        do_cmd(2'b11, 8'h3C, 1'b0, 8'h00);
        slave_en = 1'b1;
        do_cmd(2'b00, 8'h00, 1'b1, 8'h00);

        // bus stuck low during a BIT, with ignored requests while busy
        stuck = 1'b1;
        poke  = 1'b1;
        do_cmd(2'b01, 8'h01, 1'b0, 8'h00);
        stuck = 1'b0;
        poke  = 1'b0;

        // rst 100 us into RST_LOW
        slave_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_ovd   = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (100 * CDR - 1) @(posedge clk);
        @(negedge clk);
        check("abort_low", 32'(owr_e), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_release", 32'(owr_e), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        rv_cnt = 0;
        oe_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rv_cnt++;
            if (owr_e === 1'b1) oe_cnt++;
        end
        check("abort_no_rsp", 32'(rv_cnt), 32'd0);
        check("abort_bus_idle", 32'(oe_cnt), 32'd0);
        check("abort_ready_end", 32'(cmd_ready), 32'd1);

        // random commands
        for (int k = 0; k < 14; k++) begin
            r_op     = 2'($urandom_range(0, 3));
            r_ovd    = 1'($urandom_range(0, 1));
            slave_en = 1'($urandom_range(0, 1));
            do_cmd(r_op, 8'($urandom), r_ovd, r_ovd ? 8'h00 : 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/onewire_master.md
ONEWIRE_MASTER -- requirements
Module: onewire_master

Interface
REQ-001 Parameter CDR, default 50: clk cycles per 1 us timing tick (min 2).
REQ-002 Parameter OVD_EN, default 0: 1 enables the overdrive input; 0 ties overdrive off.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE; transfer occurs when cmd_valid and cmd_ready are both high on a clk edge.
REQ-007 cmd_op  input  2  operation: 00 RESET, 01 BIT, 10 BYTE, 11 reserved.
REQ-008 cmd_dat  input  8  transmit data; BIT uses bit 0; BYTE is sent LSB first.
REQ-009 cmd_ovd  input  1  overdrive timing for this command; ignored when OVD_EN=0.
REQ-010 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_dat  output  8  sampled bits, LSB first; BIT result in bit 0, other bits 0.
REQ-012 rsp_prs  output  1  presence detected; valid for RESET only, 0 otherwise.
REQ-013 rsp_err  output  1  bus still low at the end of the operation (short or stuck slave).
REQ-014 owr_e  output  1  1 pulls the bus low (open drain); 0 releases it.
REQ-015 owr_i  input  1  bus level, already synchronised by the instantiating level.

Function
REQ-016 Tick prescaler wraps at CDR-1 and restarts at 0 on command acceptance, so phase timing is exact.
REQ-017 States: IDLE, RST_LOW, RST_REC, SLOT_LOW, SLOT_REC, DONE.
REQ-018 RESET: owr_e=1 for 480 ticks (RST_LOW), then release; sample owr_i at 70 ticks after release (presence = owr_i==0); RST_REC lasts 410 ticks.
REQ-019 Bit slot: SLOT_LOW drives low 6 ticks for a 1 and 60 ticks for a 0; sample owr_i at tick 15 of the slot; slot total 70 ticks including recovery.
REQ-020 Overdrive (cmd_ovd=1, OVD_EN=1) timing in ticks: reset low 70, presence sample 8, reset recovery 40, low 1 or 8, sample 2, slot 10.
REQ-021 BYTE runs 8 consecutive slots with no idle gap; BIT runs 1 slot.
REQ-022 Reserved op: no bus activity; DONE on the next cycle with rsp_dat=0, rsp_prs=0, rsp_err=0.
REQ-023 rsp_err is owr_i==0 sampled on the last tick of the final recovery phase.
REQ-024 DONE lasts 1 cycle and asserts rsp_valid; rsp_* hold their values until the next rsp_valid.
REQ-025 cmd_valid while busy is ignored (cmd_ready=0); a command is accepted no earlier than the cycle after DONE.
REQ-026 owr_e is registered and glitch-free, changing only at phase boundaries.
REQ-027 A low bus at command acceptance does not block the operation; the fault is reported through rsp_err.

Reset
REQ-028 rst releases the bus immediately: on that edge owr_e=0 and state=IDLE, including mid-slot.
REQ-029 Reset values: cmd_ready=1 (after the reset cycle), rsp_valid=0, rsp_dat=0, rsp_prs=0, rsp_err=0, prescaler=0, tick counter=0.
REQ-030 An operation aborted by rst produces no rsp_valid.

Structure
REQ-031 Package onewire_pkg holds the op codes, the state encoding and all standard and overdrive timing constants (in ticks).
REQ-032 Sub-module onewire_tick holds the prescaler: inputs clk, rst, clr; output tick.
REQ-033 Phase counter is 10 bits wide; shift register is 8 bits.

Verification
REQ-034 RESET with onewire_slave_model on a pulled-up bus, CDR=4 -> owr_e low 480 us, rsp_prs=1, rsp_err=0, rsp_valid 890 us after accept.
REQ-035 RESET with no slave present -> rsp_prs=0, rsp_err=0.
REQ-036 BYTE cmd_dat=8'hA5 into a passive pull-up -> low pulses in order 6,60,6,60,60,6,60,6 us; rsp_dat=8'hA5.
REQ-037 BYTE cmd_dat=8'hFF while the bench holds the bus low 30 us in slots 1 and 3 -> rsp_dat=8'hF5.
REQ-038 rst asserted at 100 us into RST_LOW -> owr_e=0 on the next edge, no rsp_valid, cmd_ready=1 afterwards.
REQ-039 Bus held low permanently during BIT op 01 -> rsp_dat[0]=0, rsp_err=1; cmd_valid pulses while busy are ignored.
